// File: rtl/dual_hazard_unit_pkg.sv
// Shared definitions for the dual-issue hazard unit: forwarding select codes
// per lane, decode issue FSM states and default widths.
package dual_hazard_unit_pkg;

    localparam int REGW_DEF = 5;
    localparam int SELW_DEF = 3;

    // Lane-1 execute operand sources
    localparam int FWD_RF = 0;
    localparam int FWD_W1 = 1;
    localparam int FWD_M1 = 2;
    localparam int FWD_M2 = 3;
    localparam int FWD_W2 = 4;

    // Lane-2 execute operand sources; E1 is lane 1's ALU result of the same cycle
    localparam int FWD2_RF = 0;
    localparam int FWD2_W2 = 1;
    localparam int FWD2_M2 = 2;
    localparam int FWD2_E1 = 3;
    localparam int FWD2_M1 = 4;
    localparam int FWD2_W1 = 5;

    typedef enum logic {
        ST_PAIR   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

endpackage

// File: rtl/dual_hazard_unit_if.sv
// Decode/execute register information flowing into the hazard unit and the
// forwarding/stall controls flowing back to the pipeline.
interface dual_hazard_unit_if
    import dual_hazard_unit_pkg::*;
#(
    parameter int REGW = REGW_DEF,
    parameter int SELW = SELW_DEF
);
    logic [REGW-1:0] rsd, rtd, rsd2, rtd2;
    logic [REGW-1:0] writeregd;
    logic            regwrited, memtoregd;

    logic [REGW-1:0] rse, rte, rse2, rte2;
    logic [REGW-1:0] writerege, writerege2;
    logic            regwritee, regwritee2, memtorege, memtorege2;

    logic [SELW-1:0] forwardae, forwardbe, forwardae2, forwardbe2;
    logic            stallf, stalld, flushe, issue_single;

    modport master (
        output rsd, rtd, rsd2, rtd2, writeregd, regwrited, memtoregd,
        output rse, rte, rse2, rte2, writerege, writerege2,
        output regwritee, regwritee2, memtorege, memtorege2,
        input  forwardae, forwardbe, forwardae2, forwardbe2,
        input  stallf, stalld, flushe, issue_single
    );

    modport slave (
        input  rsd, rtd, rsd2, rtd2, writeregd, regwrited, memtoregd,
        input  rse, rte, rse2, rte2, writerege, writerege2,
        input  regwritee, regwritee2, memtorege, memtorege2,
        output forwardae, forwardbe, forwardae2, forwardbe2,
        output stallf, stalld, flushe, issue_single
    );
endinterface

// File: rtl/dual_hazard_unit_fwd_select.sv
// Priority encoder choosing the forwarding source of one execute operand.
// Younger producers win; within a stage lane 2 is the later instruction.
module fwd_select
    import dual_hazard_unit_pkg::*;
#(
    parameter int REGW = REGW_DEF,
    parameter int SELW = SELW_DEF,
    parameter int C_E1 = FWD2_E1,
    parameter int C_M2 = FWD_M2,
    parameter int C_M1 = FWD_M1,
    parameter int C_W2 = FWD_W2,
    parameter int C_W1 = FWD_W1
) (
    input  logic [REGW-1:0] src,
    input  logic            e1_en,
    input  logic [REGW-1:0] e1_dest,
    input  logic            m2_rw, m2_ld,
    input  logic [REGW-1:0] m2_dest,
    input  logic            m1_rw, m1_ld,
    input  logic [REGW-1:0] m1_dest,
    input  logic            w2_rw,
    input  logic [REGW-1:0] w2_dest,
    input  logic            w1_rw,
    input  logic [REGW-1:0] w1_dest,
    output logic [SELW-1:0] sel
);

    logic live;
    assign live = (src != '0);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = SELW'(FWD_RF);
        // M-stage loads still hold an address, so they fall through to older producers
        if (live && e1_en && e1_dest == src)                 sel = SELW'(C_E1);
        else if (live && m2_rw && !m2_ld && m2_dest == src)  sel = SELW'(C_M2);
        else if (live && m1_rw && !m1_ld && m1_dest == src)  sel = SELW'(C_M1);
        else if (live && w2_rw && w2_dest == src)            sel = SELW'(C_W2);
        else if (live && w1_rw && w1_dest == src)            sel = SELW'(C_W1);
    end

endmodule

// File: rtl/dual_hazard_unit.sv
// Forwarding and stall controller for the dual-issue pipeline: shadows the
// M/W destinations, drives execute forwarding selects and the decode split/stall FSM.
module dual_hazard_unit
    import dual_hazard_unit_pkg::*;
#(
    parameter int REGW = REGW_DEF,
    parameter int SELW = SELW_DEF
) (
    input logic              clk,
    input logic              rst_n,
    dual_hazard_unit_if.slave hz
);

    logic [REGW-1:0] m1_dest, m2_dest, w1_dest, w2_dest;
    logic            m1_rw, m1_ld, m2_rw, m2_ld, w1_rw, w2_rw;
    state_t          state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_dest <= '0; m1_rw <= 1'b0; m1_ld <= 1'b0;
            m2_dest <= '0; m2_rw <= 1'b0; m2_ld <= 1'b0;
            w1_dest <= '0; w1_rw <= 1'b0;
            w2_dest <= '0; w2_rw <= 1'b0;
        end else begin
            // NOTE: non-blocking so W takes the old M value, not this edge's E value.
            m1_dest <= hz.writerege;  m1_rw <= hz.regwritee;  m1_ld <= hz.memtorege;
            m2_dest <= hz.writerege2; m2_rw <= hz.regwritee2; m2_ld <= hz.memtorege2;
            w1_dest <= m1_dest;       w1_rw <= m1_rw;
            w2_dest <= m2_dest;       w2_rw <= m2_rw;
        end
    end

    // Same-cycle lane-1 result is only usable by lane 2 when it comes from the ALU
    logic e1_alu;
    assign e1_alu = hz.regwritee & ~hz.memtorege;

    fwd_select #(.REGW(REGW), .SELW(SELW), .C_E1(FWD_RF), .C_M2(FWD_M2),
                 .C_M1(FWD_M1), .C_W2(FWD_W2), .C_W1(FWD_W1)) u_fwd_a (
        .src(hz.rse), .e1_en(1'b0), .e1_dest(hz.writerege),
        .m2_rw(m2_rw), .m2_ld(m2_ld), .m2_dest(m2_dest),
        .m1_rw(m1_rw), .m1_ld(m1_ld), .m1_dest(m1_dest),
        .w2_rw(w2_rw), .w2_dest(w2_dest), .w1_rw(w1_rw), .w1_dest(w1_dest),
        .sel(hz.forwardae)
    );

    fwd_select #(.REGW(REGW), .SELW(SELW), .C_E1(FWD_RF), .C_M2(FWD_M2),
                 .C_M1(FWD_M1), .C_W2(FWD_W2), .C_W1(FWD_W1)) u_fwd_b (
        .src(hz.rte), .e1_en(1'b0), .e1_dest(hz.writerege),
        .m2_rw(m2_rw), .m2_ld(m2_ld), .m2_dest(m2_dest),
        .m1_rw(m1_rw), .m1_ld(m1_ld), .m1_dest(m1_dest),
        .w2_rw(w2_rw), .w2_dest(w2_dest), .w1_rw(w1_rw), .w1_dest(w1_dest),
        .sel(hz.forwardbe)
    );

    fwd_select #(.REGW(REGW), .SELW(SELW), .C_E1(FWD2_E1), .C_M2(FWD2_M2),
                 .C_M1(FWD2_M1), .C_W2(FWD2_W2), .C_W1(FWD2_W1)) u_fwd_a2 (
        .src(hz.rse2), .e1_en(e1_alu), .e1_dest(hz.writerege),
        .m2_rw(m2_rw), .m2_ld(m2_ld), .m2_dest(m2_dest),
        .m1_rw(m1_rw), .m1_ld(m1_ld), .m1_dest(m1_dest),
        .w2_rw(w2_rw), .w2_dest(w2_dest), .w1_rw(w1_rw), .w1_dest(w1_dest),
        .sel(hz.forwardae2)
    );

    fwd_select #(.REGW(REGW), .SELW(SELW), .C_E1(FWD2_E1), .C_M2(FWD2_M2),
                 .C_M1(FWD2_M1), .C_W2(FWD2_W2), .C_W1(FWD2_W1)) u_fwd_b2 (
        .src(hz.rte2), .e1_en(e1_alu), .e1_dest(hz.writerege),
        .m2_rw(m2_rw), .m2_ld(m2_ld), .m2_dest(m2_dest),
        .m1_rw(m1_rw), .m1_ld(m1_ld), .m1_dest(m1_dest),
        .w2_rw(w2_rw), .w2_dest(w2_dest), .w1_rw(w1_rw), .w1_dest(w1_dest),
        .sel(hz.forwardbe2)
    );

    function automatic logic hit(logic rw, logic [REGW-1:0] dest, logic [REGW-1:0] src);
        return rw && (dest == src) && (src != '0);
    endfunction

    logic e1_load, e2_load, lu_l1, lu_l2, lu, pl;
    assign e1_load = hz.regwritee  & hz.memtorege;
    assign e2_load = hz.regwritee2 & hz.memtorege2;

    assign lu_l1 = hit(e1_load, hz.writerege,  hz.rsd)  | hit(e1_load, hz.writerege,  hz.rtd)
                 | hit(e2_load, hz.writerege2, hz.rsd)  | hit(e2_load, hz.writerege2, hz.rtd);
    assign lu_l2 = hit(e1_load, hz.writerege,  hz.rsd2) | hit(e1_load, hz.writerege,  hz.rtd2)
                 | hit(e2_load, hz.writerege2, hz.rsd2) | hit(e2_load, hz.writerege2, hz.rtd2);

    // Lane 1 has already issued in SECOND, so only lane-2 sources can still stall
    assign lu = lu_l2 | ((state == ST_PAIR) & lu_l1);

    assign pl = hz.regwrited & hz.memtoregd & (hz.writeregd != '0)
              & ((hz.writeregd == hz.rsd2) | (hz.writeregd == hz.rtd2));

    logic split;
    assign split = ~lu & ((state == ST_SECOND) | pl);

    assign hz.flushe       = lu;
    assign hz.stallf       = lu | ((state == ST_PAIR) & pl);
    assign hz.stalld       = hz.stallf;
    assign hz.issue_single = split;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PAIR;
        end else begin
            case (state)
                ST_PAIR:   if (!lu && pl) state <= ST_SECOND;
                ST_SECOND: if (!lu)       state <= ST_PAIR;
                default:                  state <= ST_PAIR;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_hazard_unit.sv
// Scoreboard bench for dual_hazard_unit: a history-of-issued-producers model
// predicts each cycle's controls; a monitor compares them at the falling edge.
module tb_dual_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dual_hazard_unit_if #(.REGW(5), .SELW(3)) hz ();

    dual_hazard_unit #(.REGW(5), .SELW(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    typedef struct {
        logic [4:0] d;
        bit         rw;
        bit         ld;
    } prod_t;

    typedef struct {
        prod_t l1;
        prod_t l2;
    } slot_t;

    typedef struct {
        logic [2:0] fa, fb, fa2, fb2;
        bit         sf, sd, fe, is;
    } exp_t;

    slot_t hist[$];   // [0] = issued one cycle ago (M), [1] = two cycles ago (W)
    bit    second;    // lane 1 of the decode pair already issued
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic prod_t mk(logic [4:0] d, bit rw, bit ld);
        prod_t p;
        p.d = d; p.rw = rw; p.ld = ld;
        return p;
    endfunction

    task automatic reset_model();
        slot_t z;
        z.l1 = mk(5'd0, 1'b0, 1'b0);
        z.l2 = mk(5'd0, 1'b0, 1'b0);
        hist = '{z, z};
        second = 1'b0;
    endtask

    // Youngest-first scan over older instructions, M-stage loads skipped
    function automatic logic [2:0] pick(logic [4:0] src, bit lane2, prod_t e1);
        prod_t order[4];
        int    code[4];
        if (src == 5'd0) return 3'd0;
        if (lane2 && e1.rw && !e1.ld && e1.d == src) return 3'd3;
        order = '{hist[0].l2, hist[0].l1, hist[1].l2, hist[1].l1};
        if (lane2) code = '{2, 4, 1, 5};
        else       code = '{3, 2, 4, 1};
        for (int k = 0; k < 4; k++) begin
            if (order[k].rw && order[k].d == src && !(k < 2 && order[k].ld))
                return 3'(code[k]);
        end
        return 3'd0;
    endfunction

    task automatic evaluate(output exp_t x, output bit nxt);
        prod_t      e1, e2;
        logic [4:0] srcs[$];
        bit         lu, pl;
        e1 = mk(hz.writerege,  hz.regwritee,  hz.memtorege);
        e2 = mk(hz.writerege2, hz.regwritee2, hz.memtorege2);
        x.fa  = pick(hz.rse,  1'b0, e1);
        x.fb  = pick(hz.rte,  1'b0, e1);
        x.fa2 = pick(hz.rse2, 1'b1, e1);
        x.fb2 = pick(hz.rte2, 1'b1, e1);
        srcs = '{hz.rsd2, hz.rtd2};
        if (!second) begin
            srcs.push_back(hz.rsd);
            srcs.push_back(hz.rtd);
        end
        lu = 1'b0;
        foreach (srcs[i]) begin
            if (srcs[i] != 0 && e1.rw && e1.ld && e1.d == srcs[i]) lu = 1'b1;
            if (srcs[i] != 0 && e2.rw && e2.ld && e2.d == srcs[i]) lu = 1'b1;
        end
        pl = hz.regwrited && hz.memtoregd && hz.writeregd != 0 &&
             (hz.writeregd == hz.rsd2 || hz.writeregd == hz.rtd2);
        x.fe = lu;
        x.sf = lu || (!second && pl);
        x.sd = x.sf;
        x.is = !lu && (second || pl);
        nxt  = lu ? second : (!second && pl);
    endtask

    // Called just after a rising edge with inputs set; returns just after the next one
    task automatic step();
        exp_t  x;
        bit    nxt;
        slot_t s;
        if (!rst_n) reset_model();
        evaluate(x, nxt);
        exp_q.push_back(x);
        s.l1 = mk(hz.writerege,  hz.regwritee,  hz.memtorege);
        s.l2 = mk(hz.writerege2, hz.regwritee2, hz.memtorege2);
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else begin
            hist.push_front(s);
            void'(hist.pop_back());
            second = nxt;
        end
        #1;
    endtask

    task automatic nop();
        hz.rsd = 0; hz.rtd = 0; hz.rsd2 = 0; hz.rtd2 = 0;
        hz.writeregd = 0; hz.regwrited = 0; hz.memtoregd = 0;
        hz.rse = 0; hz.rte = 0; hz.rse2 = 0; hz.rte2 = 0;
        hz.writerege = 0; hz.writerege2 = 0;
        hz.regwritee = 0; hz.regwritee2 = 0; hz.memtorege = 0; hz.memtorege2 = 0;
    endtask

    task automatic rand_in();
        hz.rsd  = 5'($urandom_range(0, 3)); hz.rtd  = 5'($urandom_range(0, 3));
        hz.rsd2 = 5'($urandom_range(0, 3)); hz.rtd2 = 5'($urandom_range(0, 3));
        hz.writeregd = 5'($urandom_range(0, 3));
        hz.regwrited = ($urandom_range(0, 3) != 0);
        hz.memtoregd = ($urandom_range(0, 2) == 0);
        hz.rse  = 5'($urandom_range(0, 3)); hz.rte  = 5'($urandom_range(0, 3));
        hz.rse2 = 5'($urandom_range(0, 3)); hz.rte2 = 5'($urandom_range(0, 3));
        hz.writerege  = 5'($urandom_range(0, 3));
        hz.writerege2 = 5'($urandom_range(0, 3));
        hz.regwritee  = ($urandom_range(0, 3) != 0);
        hz.regwritee2 = ($urandom_range(0, 3) != 0);
        hz.memtorege  = ($urandom_range(0, 3) == 0);
        hz.memtorege2 = ($urandom_range(0, 3) == 0);
    endtask

    // Monitor: the controls are valid every cycle, compared mid-cycle
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("forwardae",    32'(hz.forwardae),    32'(x.fa));
                check("forwardbe",    32'(hz.forwardbe),    32'(x.fb));
                check("forwardae2",   32'(hz.forwardae2),   32'(x.fa2));
                check("forwardbe2",   32'(hz.forwardbe2),   32'(x.fb2));
                check("stallf",       32'(hz.stallf),       32'(x.sf));
                check("stalld",       32'(hz.stalld),       32'(x.sd));
                check("flushe",       32'(hz.flushe),       32'(x.fe));
                check("issue_single", 32'(hz.issue_single), 32'(x.is));
            end
        end
    end

    initial begin
        reset_model();
        rst_n = 1'b0;
        nop();
        @(posedge clk); #1;
        step(); step();
        rst_n = 1'b1;

        // M lane 1 ALU writes r5; then both M lanes write r5
        nop(); hz.writerege = 5; hz.regwritee = 1; step();
        nop(); hz.rse = 5; step();
        nop(); hz.writerege = 5; hz.regwritee = 1; hz.writerege2 = 5; hz.regwritee2 = 1; step();
        nop(); hz.rse = 5; step();

        // Same-cycle lane-1 ALU result to lane 2, then the same as a load
        nop(); hz.writerege = 7; hz.regwritee = 1; hz.rse2 = 7; step();
        nop(); hz.writerege = 7; hz.regwritee = 1; hz.memtorege = 1; hz.rse2 = 7; step();

        // E lane-2 load r9 with decode rtd = 9: one stall, then W lane-2 forward
        nop(); hz.writerege2 = 9; hz.regwritee2 = 1; hz.memtorege2 = 1; hz.rtd = 9; step();
        nop(); hz.rtd = 9; step();
        nop(); hz.rte = 9; step();

        // Intra-pair load: lw r3 in lane 1, lane 2 reads r3
        nop(); hz.writeregd = 3; hz.regwrited = 1; hz.memtoregd = 1; hz.rsd2 = 3; step();
        nop(); hz.writeregd = 3; hz.regwrited = 1; hz.memtoregd = 1; hz.rsd2 = 3;
        hz.writerege = 3; hz.regwritee = 1; hz.memtorege = 1; step();
        nop(); hz.writeregd = 3; hz.regwrited = 1; hz.memtoregd = 1; hz.rsd2 = 3; step();
        nop(); hz.rse2 = 3; step();

        // r0 is never a hazard or a forwarding source
        for (int i = 0; i < 3; i++) begin
            nop();
            hz.regwritee = 1; hz.regwritee2 = 1; hz.memtorege = (i == 1); hz.memtorege2 = 1;
            hz.regwrited = 1; hz.memtoregd = 1;
            step();
        end

        // Reset asserted mid-SECOND with live shadows
        nop(); hz.writerege = 6; hz.regwritee = 1; hz.writerege2 = 6; hz.regwritee2 = 1;
        hz.writeregd = 2; hz.regwrited = 1; hz.memtoregd = 1; hz.rtd2 = 2; step();
        rst_n = 1'b0;
        nop(); hz.rse = 6; hz.rte = 6; hz.rse2 = 6;
        hz.writeregd = 2; hz.regwrited = 1; hz.memtoregd = 1; hz.rtd2 = 2; step();
        rst_n = 1'b1;
        nop(); step();

        // Random traffic with small register indices to force collisions
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            rand_in();
            step();
        end
        rst_n = 1'b1;
        nop();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
